// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative RV32M/RV64M multiply/divide unit for the execute stage.
//
// It works on operand magnitudes and produces one result bit per cycle. A
// multiply is a shift-add into a 2N-bit accumulator. A divide is a restoring
// shift-subtract. Signs are applied in a single FIX cycle at the end. While
// the operation runs, the unit holds IF/ID/EX through `stall`. The result is
// presented for one cycle with `done`.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             valid, unflushed M-extension instruction in EX
//   funct3            000 MUL .. 111 REMU
//   is_word_op        W-form op (only meaningful when XLEN=64)
//   src_a, src_b      forwarded rs1 / rs2
//   flush             abort whatever is in flight
//   stall             hold request to the hazard unit (combinational)
//   done              one-cycle pulse, result valid
//   result            product / quotient / remainder
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            is_word_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  // latched operation
  logic [2:0]        op_q;
  logic              word_q, sa_q, sb_q;
  logic [CW-1:0]     cnt;
  // mul: acc = running product, mcand = shifted multiplicand, opb = multiplier
  // div: acc = {remainder, dividend/quotient}, opb = divisor
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   opb;

  // W-form results are the low 32 bits sign-extended to XLEN
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] x, input logic w);
    return w ? XLEN'($signed(x[31:0])) : x;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand preparation (decoded in IDLE from the live inputs)
  // ---------------------------------------------------------------------------
  logic            word_in, a_msb, b_msb, sa_in, sb_in, div_in;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] mask, a_n, b_n, a_min, mag_a, mag_b, div_init, spec_res;

  always_comb begin
    word_in  = (XLEN == 32) || is_word_op;
    mask     = word_in ? XLEN'(32'hFFFF_FFFF) : '1;
    a_n      = src_a & mask;
    b_n      = src_b & mask;
    a_msb    = word_in ? src_a[31] : src_a[XLEN-1];
    b_msb    = word_in ? src_b[31] : src_b[XLEN-1];
    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 for MUL/MULH/DIV/REM.
    // Unsigned operands are zero-extended, so their "sign" is simply 0.
    sa_in    = a_msb & (funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11));
    sb_in    = b_msb & (funct3[2] ? ~funct3[0] : ~funct3[1]);
    mag_a    = sa_in ? ((-a_n) & mask) : a_n;
    mag_b    = sb_in ? ((-b_n) & mask) : b_n;
    // dividend's MSB must sit at bit XLEN-1 so N shifts consume exactly N bits
    div_init = word_in ? (mag_a << (XLEN - 32)) : mag_a;

    div_in   = funct3[2];
    a_min    = word_in ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    b_zero   = (b_n == '0);
    ovf      = ~funct3[0] & (a_n == a_min) & (b_n == mask);
    special  = div_in & (b_zero | ovf);

    // divide-by-zero: q = all ones, r = dividend; overflow: q = dividend, r = 0
    if (b_zero) spec_res = funct3[1] ? a_n : mask;
    else        spec_res = funct3[1] ? '0  : a_n;
  end

  // ---------------------------------------------------------------------------
  // CALC step (restoring divide) and FIX result select
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     trial, diff;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_hi, q_s, r_s, fix_raw;

  always_comb begin
    trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    // diff[XLEN] set means trial < divisor (remainder < divisor <= 2^XLEN-1)
    diff  = trial - {1'b0, opb};

    prod_s  = (sa_q ^ sb_q) ? -acc : acc;
    mul_hi  = word_q ? XLEN'(prod_s[63:32]) : prod_s[2*XLEN-1:XLEN];
    q_s     = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r_s     = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    if (op_q[2])               fix_raw = op_q[1] ? r_s : q_s;
    else if (op_q[1:0] == '0)  fix_raw = prod_s[XLEN-1:0];
    else                       fix_raw = mul_hi;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          stall     = 1'b1;
          state_nxt = special ? DONE : CALC;
        end
        CALC: begin
          stall = 1'b1;
          if (cnt == CW'(1)) state_nxt = FIX;
        end
        FIX: begin
          stall     = 1'b1;
          state_nxt = DONE;
        end
        DONE: begin
          // start here is still the same instruction, so it is ignored
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (reset) begin
      stall = 1'b0;
      done  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      word_q <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      opb    <= '0;
      result <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (start) begin
          op_q   <= funct3;
          word_q <= word_in;
          sa_q   <= sa_in;
          sb_q   <= sb_in;
          cnt    <= word_in ? CW'(32) : CW'(XLEN);
          opb    <= mag_b;
          mcand  <= {{XLEN{1'b0}}, mag_a};
          acc    <= div_in ? {{XLEN{1'b0}}, div_init} : '0;
          if (special) result <= ext(spec_res, word_in);
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (op_q[2]) begin
            if (!diff[XLEN]) acc <= {diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
            else             acc <= {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
          end else begin
            if (opb[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end
        end
        FIX: result <= ext(fix_raw, word_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        start32 = 1'b0;
  logic        start64 = 1'b0;
  logic        flush   = 1'b0;
  logic        is_word = 1'b0;
  logic [2:0]  funct3  = '0;
  logic [63:0] src_a   = '0;
  logic [63:0] src_b   = '0;
  logic        stall32, done32, stall64, done64;
  logic [31:0] result32;
  logic [63:0] result64;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .funct3(funct3),
    .is_word_op(is_word), .src_a(src_a[31:0]), .src_b(src_b[31:0]),
    .flush(flush), .stall(stall32), .done(done32), .result(result32)
  );

  ex_muldiv #(.XLEN(64)) u_dut64 (
    .clk(clk), .reset(reset), .start(start64), .funct3(funct3),
    .is_word_op(is_word), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(stall64), .done(done64), .result(result64)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: plain wide arithmetic on extended operands
  // ---------------------------------------------------------------------------
  function automatic int op_n(input int xl, input logic w);
    return (xl == 32 || w) ? 32 : 64;
  endfunction

  function automatic logic signed [127:0] opnd(input int n, input logic sgn, input logic [63:0] v);
    if (n == 32) return sgn ? {{96{v[31]}}, v[31:0]} : {96'b0, v[31:0]};
    return sgn ? {{64{v[63]}}, v} : {64'b0, v};
  endfunction

  function automatic logic sgn_a(input logic [2:0] f);
    return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
  endfunction

  function automatic logic sgn_b(input logic [2:0] f);
    return f inside {3'd0, 3'd1, 3'd4, 3'd6};
  endfunction

  function automatic logic is_special(input int xl, input logic [2:0] f, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    int n;
    logic signed [127:0] A, B, mn;
    n  = op_n(xl, w);
    A  = opnd(n, sgn_a(f), a);
    B  = opnd(n, sgn_b(f), b);
    mn = -(128'sd1 <<< (n - 1));
    return f[2] && (B == 0 || (!f[0] && A == mn && B == -1));
  endfunction

  function automatic logic [63:0] model(input int xl, input logic [2:0] f, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    int n;
    logic signed [127:0] A, B, r, mn;
    n  = op_n(xl, w);
    A  = opnd(n, sgn_a(f), a);
    B  = opnd(n, sgn_b(f), b);
    mn = -(128'sd1 <<< (n - 1));
    if (!f[2]) begin
      r = A * B;
      if (f != 3'd0) r = r >>> n;
    end else if (B == 0) begin
      r = f[1] ? A : -128'sd1;
    end else if (!f[0] && A == mn && B == -1) begin
      r = f[1] ? 128'sd0 : A;
    end else begin
      r = f[1] ? (A % B) : (A / B);
    end
    if (n == 32) return {{32{r[31]}}, r[31:0]};
    return r[63:0];
  endfunction

  function automatic int model_lat(input int xl, input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    return is_special(xl, f, w, a, b) ? 1 : op_n(xl, w) + 2;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: entered just after a rising edge (that cycle is cycle 0), holds
  // start through DONE like the pipeline would, returns just after the edge
  // that ends DONE so a following call issues in the earliest legal cycle.
  // lat = cycle index of done (-1 on timeout); stall_err counts cycles where
  // stall disagreed with "high before done, low at done".
  // ---------------------------------------------------------------------------
  task automatic run_op(input int xl, input logic [2:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output int stall_err);
    funct3  = f;
    is_word = w;
    src_a   = a;
    src_b   = b;
    if (xl == 32) start32 = 1'b1; else start64 = 1'b1;
    lat = -1; stall_err = 0; res = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ((xl == 32) ? done32 : done64) begin
        lat = c;
        res = (xl == 32) ? {32'b0, result32} : result64;
        if ((xl == 32) ? stall32 : stall64) stall_err++;
        break;
      end
      if (!((xl == 32) ? stall32 : stall64)) stall_err++;
    end
    @(posedge clk); #1;
    start32 = 1'b0;
    start64 = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    start32 = 1'b1; start64 = 1'b1; funct3 = 3'd0; src_a = 64'd3; src_b = 64'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (stall32 !== 1'b0 || stall64 !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall got %b/%b expected 0/0", stall32, stall64);
    end
    n_chk++;
    if (done32 !== 1'b0 || done64 !== 1'b0) begin
      n_fail++; $display("FAIL reset_done got %b/%b expected 0/0", done32, done64);
    end
    n_chk++;
    if (result32 !== 32'd0 || result64 !== 64'd0) begin
      n_fail++; $display("FAIL reset_result got %h/%h expected 0/0", result32, result64);
    end
    @(posedge clk); #1;
    reset = 1'b0; start32 = 1'b0; start64 = 1'b0;
  endtask

  task automatic test_mul();
    logic [63:0] res; int lat, se;
    run_op(32, 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFD, res, lat, se);
    n_chk++;
    if (res[31:0] !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL mul_neg result got %h expected ffffffeb", res[31:0]);
    end
    n_chk++;
    if (lat != 34) begin n_fail++; $display("FAIL mul_neg done_cycle got %0d expected 34", lat); end
    n_chk++;
    if (se != 0) begin n_fail++; $display("FAIL mul_neg stall_profile got %0d bad cycles expected 0", se); end
  endtask

  task automatic test_mulh();
    logic [2:0]  f[3]   = '{3'd3, 3'd1, 3'd2};
    logic [31:0] exp[3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [63:0] res; int lat, se;
    for (int i = 0; i < 3; i++) begin
      run_op(32, f[i], 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, res, lat, se);
      n_chk++;
      if (res[31:0] !== exp[i] || lat != 34 || se != 0) begin
        n_fail++;
        $display("FAIL mulh f=%0d got %h lat %0d stall_err %0d expected %h lat 34", f[i], res[31:0], lat, se, exp[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f[4]   = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] a[4]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b[4]   = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [63:0] res; int lat, se;
    for (int i = 0; i < 4; i++) begin
      run_op(32, f[i], 1'b0, {32'b0, a[i]}, {32'b0, b[i]}, res, lat, se);
      n_chk++;
      if (res[31:0] !== exp[i] || lat != 34 || se != 0) begin
        n_fail++;
        $display("FAIL div f=%0d got %h lat %0d stall_err %0d expected %h lat 34", f[i], res[31:0], lat, se, exp[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f[4]   = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] a[4]   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b[4]   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [63:0] res; int lat, se;
    for (int i = 0; i < 4; i++) begin
      run_op(32, f[i], 1'b0, {32'b0, a[i]}, {32'b0, b[i]}, res, lat, se);
      n_chk++;
      if (res[31:0] !== exp[i] || lat != 1 || se != 0) begin
        n_fail++;
        $display("FAIL special f=%0d got %h lat %0d stall_err %0d expected %h lat 1", f[i], res[31:0], lat, se, exp[i]);
      end
    end
  endtask

  task automatic test_done_pulse();
    logic [63:0] res; int lat, se;
    run_op(32, 3'd0, 1'b0, 64'd3, 64'd4, res, lat, se);
    // now in the cycle after DONE, start low
    @(negedge clk);
    n_chk++;
    if (done32 !== 1'b0 || stall32 !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse done/stall got %b/%b expected 0/0", done32, stall32);
    end
    n_chk++;
    if (result32 !== 32'd12) begin
      n_fail++; $display("FAIL result_hold got %h expected 0000000c", result32);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int lat, se;
    run_op(32, 3'd3, 1'b0, 64'h8000_0000, 64'd6, res, lat, se);
    n_chk++;
    if (res[31:0] !== 32'd3 || lat != 34) begin
      n_fail++; $display("FAIL b2b_first got %h lat %0d expected 00000003 lat 34", res[31:0], lat);
    end
    run_op(32, 3'd7, 1'b0, 64'd1000, 64'd33, res, lat, se);
    n_chk++;
    if (res[31:0] !== 32'd10 || lat != 34 || se != 0) begin
      n_fail++; $display("FAIL b2b_second got %h lat %0d stall_err %0d expected 0000000a lat 34", res[31:0], lat, se);
    end
  endtask

  task automatic test_flush();
    logic [63:0] res; int lat, se, bad;
    bad = 0;
    funct3 = 3'd0; is_word = 1'b0; src_a = 64'd5; src_b = 64'd6; start32 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done32 || !stall32) bad++;
      @(posedge clk); #1;
    end
    flush = 1'b1;                      // cycle 10
    @(negedge clk);
    n_chk++;
    if (bad != 0 || stall32 !== 1'b0 || done32 !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle stall/done got %b/%b (pre-bad %0d) expected 0/0", stall32, done32, bad);
    end
    @(posedge clk); #1;
    flush = 1'b0;                      // cycle 11: new instruction
    run_op(32, 3'd5, 1'b0, 64'd9, 64'd3, res, lat, se);
    n_chk++;
    if (res[31:0] !== 32'd3 || lat != 34 || se != 0) begin
      n_fail++; $display("FAIL flush_restart got %h lat %0d stall_err %0d expected 00000003 lat 34", res[31:0], lat, se);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; int lat, se;
    funct3 = 3'd0; is_word = 1'b0; src_a = 64'd9; src_b = 64'd9; start32 = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;                   // mid-CALC
    @(negedge clk);
    n_chk++;
    if (stall32 !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stall got %b expected 0", stall32); end
    @(posedge clk); #1;
    reset = 1'b0; start32 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (result32 !== 32'd0 || done32 !== 1'b0 || stall32 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_state result/done/stall got %h/%b/%b expected 0/0/0", result32, done32, stall32);
    end
    @(posedge clk); #1;
    run_op(32, 3'd0, 1'b0, 64'd9, 64'd9, res, lat, se);
    n_chk++;
    if (res[31:0] !== 32'd81 || lat != 34) begin
      n_fail++; $display("FAIL reset_mid_after got %h lat %0d expected 00000051 lat 34", res[31:0], lat);
    end
  endtask

  task automatic test_xlen64();
    logic [2:0]  f[3]   = '{3'd4, 3'd0, 3'd0};
    logic        w[3]   = '{1'b1, 1'b1, 1'b0};
    logic [63:0] a[3]   = '{64'h0000_0001_FFFF_FFF9, 64'h7FFF_FFFF, 64'h0000_0100_0000_0000};
    logic [63:0] b[3]   = '{64'd2, 64'd2, 64'd3};
    logic [63:0] exp[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0300_0000_0000};
    int          el[3]  = '{34, 34, 66};
    logic [63:0] res; int lat, se;
    for (int i = 0; i < 3; i++) begin
      run_op(64, f[i], w[i], a[i], b[i], res, lat, se);
      n_chk++;
      if (res !== exp[i] || lat != el[i] || se != 0) begin
        n_fail++;
        $display("FAIL xlen64 case %0d got %h lat %0d stall_err %0d expected %h lat %0d", i, res, lat, se, exp[i], el[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] res, a, b, exp; logic [2:0] f; logic w; int lat, se, elat, xl, mode;
    for (int i = 0; i < 80; i++) begin
      xl   = (i < 40) ? 32 : 64;
      f    = 3'($urandom_range(0, 7));
      w    = (xl == 64) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (w && f inside {3'd1, 3'd2, 3'd3}) w = 1'b0;
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      mode = $urandom_range(0, 9);
      if (mode == 0) b = '0;
      else if (mode == 1) begin
        a = (op_n(xl, w) == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        b = '1;
      end else if (mode == 2) b = 64'($urandom_range(1, 20));
      else if (mode == 3) a = 64'($urandom_range(0, 50));
      exp  = model(xl, f, w, a, b);
      elat = model_lat(xl, f, w, a, b);
      run_op(xl, f, w, a, b, res, lat, se);
      if (xl == 32) begin res = {32'b0, res[31:0]}; exp = {32'b0, exp[31:0]}; end
      n_chk++;
      if (res !== exp) begin
        n_fail++;
        $display("FAIL rand%0d x%0d f=%0d w=%b a=%h b=%h got %h expected %h", i, xl, f, w, a, b, res, exp);
      end
      n_chk++;
      if (lat != elat || se != 0) begin
        n_fail++;
        $display("FAIL rand%0d_timing x%0d f=%0d got lat %0d stall_err %0d expected lat %0d", i, xl, f, lat, se, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_done_pulse();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_xlen64();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M/RV64M multiply/divide unit in the execute stage, beside the single-cycle ALU. It accepts post-forwarding operands `src_a` and `src_b` plus `funct3` from the ID/EX register. It computes one result bit per cycle and holds the front of the pipeline through a stall request to the hazard unit until the result is ready. The result joins the EX/MEM `ALUResult` path in the cycle `done` is high.

## Interface
Parameters:
- `XLEN`, 32. Datapath width; legal values are 32 and 64.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  EX holds a valid M-extension instruction that has not been flushed
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `is_word_op`  in  1  W-form (MULW/DIVW/DIVUW/REMW/REMUW); ignored when XLEN=32
- `src_a`, `src_b`  in  XLEN  forwarded operands (rs1, rs2)
- `flush`  in  1  kill the operation in progress
- `stall`  out  1  to hazard unit; freezes IF/ID/EX
- `done`  out  1  one-cycle pulse; `result` is valid
- `result`  out  XLEN  product or quotient/remainder

## Operation
- **Operation width.** N = 32 if XLEN=32 or `is_word_op`=1; otherwise N = XLEN.
- **Word operands.** For word ops, take the low 32 bits of each operand. Sign-extend them for signed ops and zero-extend for DIVUW/REMUW. Sign-extend `result` from bit 31 to XLEN.
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE.**
  - `start` & ~`flush` latches the operands, `funct3`, N and the operand signs, then moves to CALC.
  - Divide special cases go straight to DONE instead.
- **CALC.** Runs N cycles on operand magnitudes, controlled by a log2(XLEN)+1-bit down-counter.
  - Multiply: shift-add into a 2N-bit accumulator.
  - Divide: restoring shift-subtract.
  - When the counter reaches 0, move to FIX.
- **FIX (1 cycle).** Applies sign correction and selects the result.
  - Product sign is sa^sb. For MULHSU only sa counts; for MULHU, DIVU and REMU both signs are 0.
  - Quotient sign is sa^sb. Remainder sign is sa.
  - MUL/MULW return the low N bits of the product; MULH* return the high N bits.
- **DONE (1 cycle).** `done`=1 and `result` is registered and stable. Next state is IDLE unconditionally.
- **Divide special cases** (next state is DONE directly):
  - Divisor = 0: quotient = all ones; remainder = dividend (N-bit, then extended).
  - Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.
- **`stall`** = ~`flush` & ((IDLE & `start`) | CALC | FIX). It is combinational and is 0 in DONE, so the EX instruction advances on the edge ending DONE.
- **`start` outside IDLE** is ignored, including in DONE, where it is still the same instruction.
- **`flush`** has priority over everything. Any state goes to IDLE on the next edge, `done` is suppressed and `stall`=0 that cycle. The aborted result is never emitted.
- **Illegal input** (`is_word_op` with funct3 001–011 at XLEN=64): `result` is unspecified. The unit must still follow the normal N=32 timing and return to IDLE, and must never hang.
- **`reset`** forces IDLE, `done`=0, `result`=0, counter=0 and `stall`=0 regardless of `start`.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
- Normal operations:
  - `stall` is high in cycles 0..N+1.
  - CALC occupies cycles 1..N, FIX is cycle N+1, and `done`=1 in cycle N+2.
  - The instruction leaves EX at the end of cycle N+2.
- Divide special cases: `stall` is high in cycle 0 only and `done`=1 in cycle 1.
- Back-to-back operations: a second M instruction is accepted in IDLE at cycle N+3 at the earliest, i.e. one idle bubble after DONE.
- `result` holds its value from DONE until the next FIX or special-case load. It is valid only when `done`=1.
- `flush` in cycle k means state is IDLE at k+1, and a new `start` at k+1 is accepted.

## Test plan
- **XLEN=32, MUL 7 × 0xFFFFFFFD (−3):**
  - `stall` is high in cycles 0..33.
  - `done` is high in cycle 34 with `result`=0xFFFFFFEB.
  - `stall` is low in cycle 34.
- **High-half multiplies, a=b=0xFFFFFFFF:**
  - MULHU gives 0xFFFFFFFE.
  - MULH gives 0x00000000.
  - MULHSU gives 0xFFFFFFFF.
- **Signed divide, −7 by 2:**
  - DIV gives 0xFFFFFFFD.
  - REM gives 0xFFFFFFFF.
  - DIVU 100/7 gives 14 and REMU 100/7 gives 2, each with `done` in cycle 34.
- **Special cases, each with `done` in cycle 1:**
  - DIV 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM on the same operands gives 0.
- **Flush mid-operation:** start MUL, assert `flush` in cycle 10.
  - `done` never rises for it and `stall` is 0 from cycle 10.
  - A new DIVU 9/3 started in cycle 11 returns 3 in cycle 45.
  - `reset` asserted mid-CALC gives IDLE and `result`=0.
- **XLEN=64:**
  - DIVW a=0x00000001FFFFFFF9, b=2 gives 0xFFFFFFFFFFFFFFFD in cycle 34.
  - MULW 0x7FFFFFFF × 2 gives 0xFFFFFFFFFFFFFFFE.
  - 64-bit MUL 2^40 × 3 gives 0x0000030000000000 in cycle 66.
